hazard_tracker: RTL and testbench

Producer side of the register-forwarding interface in the 5-stage LEGv8 pipeline. Tracks the destination tag of every instruction in flight through EX, MEM and WB, and drives the `EX_id`/`EX_enable`/`MEM_id`/`MEM_enable` signals that the forwarding mux consumes. Detects the hazards that forwarding cannot resolve and drives the pipeline stall and bubble controls:
- load-use;
- multi-cycle data-memory wait.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/stage_tag_reg.sv | 24 ++
 rtl/hazard_tracker.sv | 94 +++++++++
 tb/tb_hazard_tracker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
package hazard_pkg;

  localparam logic [4:0] XZR   = 5'd31;
  localparam int         CNT_W = 16;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  // A tag is a forwardable pending write only if it is real, writes, and is not XZR.
  function automatic logic tag_enable(input stage_tag_t t);
    return t.valid & t.regwrite & (t.rd != XZR);
  endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline-stage destination tag register with hold and kill controls.
module stage_tag_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hold,
  input  logic       kill,
  input  stage_tag_t d,
  output stage_tag_t q
);

  // Kill beats hold so a frozen stage can still be turned into a bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= TAG_BUBBLE;
    end else if (kill) begin
      q <= TAG_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks EX/MEM/WB destination tags, decodes load-use and memory-wait hazards,
// and drives stall/bubble/freeze controls plus a saturating stall counter.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_Aa,
  input  logic [4:0]       id_Ab,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [4:0]       EX_id,
  output logic [4:0]       MEM_id,
  output logic [4:0]       WB_id,
  output logic             EX_enable,
  output logic             MEM_enable,
  output logic             WB_enable,
  output logic [CNT_W-1:0] stall_cycles
);

  stage_tag_t id_tag, ex_tag, mem_tag, wb_tag;
  logic       mem_wait, load_use, ex_kill;

  assign id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // Hazard decode; mem_wait dominates, then flush, then load_use.
  always_comb begin
    mem_wait = mem_tag.valid & mem_tag.memread & ~mem_ready;
    load_use = ex_tag.valid & ex_tag.memread & ex_tag.regwrite & (ex_tag.rd != XZR) & id_valid &
               ((id_uses_a & (id_Aa == ex_tag.rd)) | (id_uses_b & (id_Ab == ex_tag.rd)));
    ex_kill   = ~mem_wait & (flush | load_use);
    // Controls are forced low in reset so a stall caught mid-flight does not leak out.
    freeze    = reset_n & mem_wait;
    stall_if  = reset_n & (mem_wait | (~flush & load_use));
    bubble_ex = reset_n & ex_kill;
  end

  stage_tag_reg u_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (mem_wait),
    .kill    (ex_kill),
    .d       (id_tag),
    .q       (ex_tag)
  );

  stage_tag_reg u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (mem_wait),
    .kill    (1'b0),
    .d       (ex_tag),
    .q       (mem_tag)
  );

  // While MEM waits, WB receives a bubble so the completed instruction is not written twice.
  stage_tag_reg u_wb (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (1'b0),
    .kill    (mem_wait),
    .d       (mem_tag),
    .q       (wb_tag)
  );

  // Forwarding tags come straight from the stage registers.
  always_comb begin
    EX_id      = ex_tag.rd;
    MEM_id     = mem_tag.rd;
    WB_id      = wb_tag.rd;
    EX_enable  = tag_enable(ex_tag);
    MEM_enable = tag_enable(mem_tag);
    WB_enable  = tag_enable(wb_tag);
  end

  // Saturating count of cycles in which the front end is held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall_if && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed self-checking bench for hazard_tracker.
module tb_hazard_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_Aa, id_Ab, id_rd;
  logic        id_uses_a, id_uses_b, id_regwrite, id_memread;
  logic        flush, mem_ready;
  logic        stall_if, bubble_ex, freeze;
  logic [4:0]  EX_id, MEM_id, WB_id;
  logic        EX_enable, MEM_enable, WB_enable;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stalls = '0;

  hazard_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_Aa        (id_Aa),
    .id_Ab        (id_Ab),
    .id_uses_a    (id_uses_a),
    .id_uses_b    (id_uses_b),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .stall_if     (stall_if),
    .bubble_ex    (bubble_ex),
    .freeze       (freeze),
    .EX_id        (EX_id),
    .MEM_id       (MEM_id),
    .WB_id        (WB_id),
    .EX_enable    (EX_enable),
    .MEM_enable   (MEM_enable),
    .WB_enable    (WB_enable),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] aa, input logic ua, input logic [4:0] ab, input logic ub);
    id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
    id_Aa = aa; id_uses_a = ua; id_Ab = ab; id_uses_b = ub;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    flush = 1'b0; mem_ready = 1'b1;
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    idle();
    tick(); tick();
    checks++;
    if ({EX_id, MEM_id, WB_id} !== 15'd0) begin
      errors++; $display("FAIL reset_ids got %h/%h/%h want 0", EX_id, MEM_id, WB_id);
    end
    checks++;
    if ({EX_enable, MEM_enable, WB_enable, stall_if, bubble_ex, freeze} !== 6'd0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {EX_enable, MEM_enable, WB_enable, stall_if, bubble_ex, freeze});
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %h want 0", stall_cycles);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({EX_enable, MEM_enable, WB_enable, stall_if, bubble_ex, freeze} !== 6'd0) begin
      errors++; $display("FAIL post_reset_ctrl got %b want 000000",
                         {EX_enable, MEM_enable, WB_enable, stall_if, bubble_ex, freeze});
    end
  endtask

  task automatic test_pass_through();
    drain();
    issue(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    checks++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL pt_nostall got stall_if=%b bubble_ex=%b want 0 0", stall_if, bubble_ex);
    end
    tick(); idle();
    checks++;
    if (EX_id !== 5'd3 || EX_enable !== 1'b1) begin
      errors++; $display("FAIL pt_ex got %0d/%b want 3/1", EX_id, EX_enable);
    end
    tick();
    checks++;
    if (MEM_id !== 5'd3 || MEM_enable !== 1'b1 || EX_enable !== 1'b0) begin
      errors++; $display("FAIL pt_mem got %0d/%b ex_en=%b want 3/1 ex_en=0", MEM_id, MEM_enable, EX_enable);
    end
    tick();
    checks++;
    if (WB_id !== 5'd3 || WB_enable !== 1'b1 || stall_if !== 1'b0) begin
      errors++; $display("FAIL pt_wb got %0d/%b stall=%b want 3/1 stall=0", WB_id, WB_enable, stall_if);
    end
  endtask

  task automatic test_zero_reg();
    drain();
    issue(1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    checks++;
    if (EX_id !== 5'd31 || EX_enable !== 1'b0) begin
      errors++; $display("FAIL xzr_ex got %0d/%b want 31/0", EX_id, EX_enable);
    end
    tick();
    checks++;
    if (MEM_enable !== 1'b0) begin
      errors++; $display("FAIL xzr_mem got %b want 0", MEM_enable);
    end
    tick();
    checks++;
    if (WB_id !== 5'd31 || WB_enable !== 1'b0) begin
      errors++; $display("FAIL xzr_wb got %0d/%b want 31/0", WB_id, WB_enable);
    end
  endtask

  task automatic test_load_use();
    // Dependency through Aa.
    drain();
    issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
    checks++;
    if (stall_if !== 1'b1 || bubble_ex !== 1'b1 || freeze !== 1'b0) begin
      errors++; $display("FAIL lu_a_ctrl got stall=%b bub=%b frz=%b want 1 1 0", stall_if, bubble_ex, freeze);
    end
    tick(); exp_stalls++;
    checks++;
    if (EX_enable !== 1'b0 || MEM_id !== 5'd5 || MEM_enable !== 1'b1 || stall_if !== 1'b0) begin
      errors++; $display("FAIL lu_a_after got ex_en=%b mem=%0d/%b stall=%b want 0 5/1 0",
                         EX_enable, MEM_id, MEM_enable, stall_if);
    end
    tick(); idle();
    checks++;
    if (EX_id !== 5'd6 || EX_enable !== 1'b1 || stall_cycles !== exp_stalls) begin
      errors++; $display("FAIL lu_a_issue got ex=%0d/%b cnt=%0d want 6/1 cnt=%0d",
                         EX_id, EX_enable, stall_cycles, exp_stalls);
    end
    // Same register but not actually read: no stall.
    drain();
    issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b0, 5'd2, 1'b1);
    checks++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL lu_nouse got stall=%b bub=%b want 0 0", stall_if, bubble_ex);
    end
    // Dependency through Ab.
    drain();
    issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1);
    checks++;
    if (stall_if !== 1'b1 || bubble_ex !== 1'b1) begin
      errors++; $display("FAIL lu_b_ctrl got stall=%b bub=%b want 1 1", stall_if, bubble_ex);
    end
    tick(); exp_stalls++;
    idle();
  endtask

  task automatic test_mem_wait();
    drain();
    issue(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (freeze !== 1'b1 || stall_if !== 1'b1 || bubble_ex !== 1'b0) begin
        errors++; $display("FAIL mw_ctrl%0d got frz=%b stall=%b bub=%b want 1 1 0",
                           i, freeze, stall_if, bubble_ex);
      end
      tick(); exp_stalls++;
      checks++;
      if (MEM_id !== 5'd7 || MEM_enable !== 1'b1 || WB_enable !== 1'b0) begin
        errors++; $display("FAIL mw_tags%0d got mem=%0d/%b wb_en=%b want 7/1 0",
                           i, MEM_id, MEM_enable, WB_enable);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b0 || stall_if !== 1'b0) begin
      errors++; $display("FAIL mw_release got frz=%b stall=%b want 0 0", freeze, stall_if);
    end
    tick();
    checks++;
    if (WB_id !== 5'd7 || WB_enable !== 1'b1 || stall_cycles !== exp_stalls) begin
      errors++; $display("FAIL mw_wb got wb=%0d/%b cnt=%0d want 7/1 cnt=%0d",
                         WB_id, WB_enable, stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_simultaneous();
    // flush together with load_use: flush wins.
    drain();
    issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    flush = 1'b1; #1;
    checks++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b1) begin
      errors++; $display("FAIL fl_lu got stall=%b bub=%b want 0 1", stall_if, bubble_ex);
    end
    tick(); flush = 1'b0; idle();
    checks++;
    if (EX_enable !== 1'b0 || MEM_id !== 5'd5) begin
      errors++; $display("FAIL fl_lu_tags got ex_en=%b mem=%0d want 0 5", EX_enable, MEM_id);
    end
    // flush during mem_wait: ignored, tags hold.
    drain();
    issue(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(1'b1, 5'd4, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    tick();
    issue(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    mem_ready = 1'b0; flush = 1'b1; #1;
    checks++;
    if (freeze !== 1'b1 || stall_if !== 1'b1 || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL fl_mw_ctrl got frz=%b stall=%b bub=%b want 1 1 0", freeze, stall_if, bubble_ex);
    end
    tick(); exp_stalls++;
    checks++;
    if (EX_id !== 5'd4 || EX_enable !== 1'b1 || MEM_id !== 5'd9 || MEM_enable !== 1'b1) begin
      errors++; $display("FAIL fl_mw_tags got ex=%0d/%b mem=%0d/%b want 4/1 9/1",
                         EX_id, EX_enable, MEM_id, MEM_enable);
    end
    flush = 1'b0; mem_ready = 1'b1; idle();
    tick();
    checks++;
    if (stall_cycles !== exp_stalls) begin
      errors++; $display("FAIL fl_mw_cnt got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    issue(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    tick();
    mem_ready = 1'b0;
    tick(); exp_stalls++;
    reset_n = 1'b0; #1;
    checks++;
    if (stall_if !== 1'b0 || freeze !== 1'b0 || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL rst_mw_ctrl got stall=%b frz=%b bub=%b want 0 0 0", stall_if, freeze, bubble_ex);
    end
    tick(); exp_stalls = '0;
    checks++;
    if ({EX_id, MEM_id, WB_id} !== 15'd0 || {EX_enable, MEM_enable, WB_enable} !== 3'd0) begin
      errors++; $display("FAIL rst_mw_tags got ids=%h en=%b want 0 000",
                         {EX_id, MEM_id, WB_id}, {EX_enable, MEM_enable, WB_enable});
    end
    checks++;
    if (stall_cycles !== exp_stalls) begin
      errors++; $display("FAIL rst_mw_cnt got %h want %h", stall_cycles, exp_stalls);
    end
    reset_n = 1'b1; mem_ready = 1'b1;
    // Saturation: hold a load in MEM long enough to reach the top of the counter.
    issue(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    tick();
    mem_ready = 1'b0;
    repeat (65534) tick();
    checks++;
    if (stall_cycles !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre got %h want fffe", stall_cycles);
    end
    repeat (3) tick();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat got %h want ffff", stall_cycles);
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_zero_reg();
    test_load_use();
    test_mem_wait();
    test_simultaneous();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
